// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment digit counter.
package seg_pkg;

    localparam int DIGIT_W        = 4;
    localparam int MAX_DIGIT_DEF  = 9;
    localparam int DEB_CYCLES_DEF = 64;
    localparam int PRESCALE_DEF   = 1000;

    // Bits needed to hold a counter running 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_step_debounce.sv
// Button synchroniser + debouncer; emits a one-cycle step_p on each accepted press.
module seg_step_debounce
    import seg_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step_p
);

    localparam int              CW   = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEB_CYCLES - 1);

    logic          btn_m;
    logic          btn_s;
    logic          deb_lvl;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
            step_p  <= 1'b0;
        end else begin
            btn_m  <= btn_raw;
            btn_s  <= btn_m;
            step_p <= 1'b0;
            if (btn_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == LAST) begin
                // Pulse is raised together with the level so the counter steps one edge later.
                deb_lvl <= btn_s;
                deb_cnt <= '0;
                step_p  <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_digit_counter.sv
// Up/down digit counter feeding the 7-segment decoder: button or auto-tick stepping, wrap and load.
module seg_digit_counter
    import seg_pkg::*;
#(
    parameter int MAX_DIGIT  = MAX_DIGIT_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PRESCALE   = PRESCALE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_step,
    input  logic               up_dn,
    input  logic               auto_en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               wrap
);

    localparam int                 PW       = cnt_w(PRESCALE);
    localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);

    logic               dir_m, dir_s;
    logic               auto_m, auto_s;
    logic               load_m, load_s;
    logic               step_p;
    logic               tick;
    logic [PW-1:0]      pre_cnt;
    logic [DIGIT_W-1:0] digit_nxt;
    logic               wrap_nxt;

    seg_step_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_step),
        .step_p (step_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_m  <= 1'b0;
            dir_s  <= 1'b0;
            auto_m <= 1'b0;
            auto_s <= 1'b0;
            load_m <= 1'b0;
            load_s <= 1'b0;
        end else begin
            dir_m  <= up_dn;
            dir_s  <= dir_m;
            auto_m <= auto_en;
            auto_s <= auto_m;
            load_m <= load;
            load_s <= load_m;
        end
    end

    // Load parks the prescaler so the first tick after release is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (auto_s && !load_s) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
            tick    <= (pre_cnt == PRE_LAST);
        end else begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end
    end

    always_comb begin
        digit_nxt = digit;
        wrap_nxt  = 1'b0;
        if (load_s) begin
            digit_nxt = (load_val > MAX_D) ? MAX_D : load_val;
        end else if (step_p || tick) begin
            if (dir_s) begin
                wrap_nxt  = (digit == MAX_D);
                digit_nxt = wrap_nxt ? '0 : digit + DIGIT_W'(1);
            end else begin
                wrap_nxt  = (digit == '0);
                digit_nxt = wrap_nxt ? MAX_D : digit - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
            wrap  <= 1'b0;
        end else begin
            digit <= digit_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_seg_digit_counter.sv
// Directed bench for seg_digit_counter with DEB_CYCLES=4, PRESCALE=5, MAX_DIGIT=9.
module tb_seg_digit_counter;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_step = 1'b0;
    logic       up_dn    = 1'b1;
    logic       auto_en  = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic       wrap;

    int n_cmp = 0;
    int n_bad = 0;
    int wraps;

    always #5 clk = ~clk;

    seg_digit_counter #(
        .MAX_DIGIT (9),
        .DEB_CYCLES(4),
        .PRESCALE  (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_step(btn_step),
        .up_dn   (up_dn),
        .auto_en (auto_en),
        .load    (load),
        .load_val(load_val),
        .digit   (digit),
        .wrap    (wrap)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run n cycles, counting wrap pulses into 'wraps'.
    task automatic run_cnt(input int n);
        wraps = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (wrap) wraps++;
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_digit", digit, 0);
        chk("rst_wrap", wrap, 0);
        rst_n = 1'b1;
        cyc(3);

        // Clean press: step lands on edge 7
        btn_step = 1'b1;
        cyc(6);
        chk("press_e6", digit, 0);
        cyc(1);
        chk("press_e7", digit, 1);
        chk("press_e7_wrap", wrap, 0);
        run_cnt(13);
        chk("press_single", digit, 1);
        chk("press_nowrap", wraps, 0);
        btn_step = 1'b0;
        cyc(10);
        chk("release_hold", digit, 1);

        // Bounce with 3-cycle levels: no step
        for (int k = 0; k < 4; k++) begin
            btn_step = (k % 2 == 0);
            cyc(3);
        end
        btn_step = 1'b0;
        cyc(10);
        chk("bounce", digit, 1);

        // Load 8, then auto-tick up through the wrap
        load_val = 4'd8;
        load = 1'b1;
        cyc(4);
        chk("load8", digit, 8);
        load = 1'b0;
        auto_en = 1'b1;
        cyc(7);
        chk("auto_e7", digit, 8);
        cyc(1);
        chk("auto_9", digit, 9);
        chk("auto_9_wrap", wrap, 0);
        cyc(4);
        chk("auto_e12", digit, 9);
        cyc(1);
        chk("auto_0", digit, 0);
        chk("auto_0_wrap", wrap, 1);
        cyc(1);
        chk("auto_wrap_1cyc", wrap, 0);
        chk("auto_0_hold", digit, 0);
        auto_en = 1'b0;
        cyc(10);
        chk("auto_off", digit, 0);

        // Down-count by button from 0: wrap to 9, then 8
        up_dn = 1'b0;
        cyc(3);
        btn_step = 1'b1;
        cyc(6);
        chk("dn_e6", digit, 0);
        cyc(1);
        chk("dn_9", digit, 9);
        chk("dn_9_wrap", wrap, 1);
        cyc(1);
        chk("dn_wrap_1cyc", wrap, 0);
        chk("dn_9_hold", digit, 9);
        btn_step = 1'b0;
        cyc(10);
        btn_step = 1'b1;
        cyc(7);
        chk("dn_8", digit, 8);
        chk("dn_8_wrap", wrap, 0);
        btn_step = 1'b0;
        cyc(10);

        // Clamped load with auto enabled; tick resumes a full period after release
        up_dn = 1'b1;
        cyc(3);
        load_val = 4'd12;
        load = 1'b1;
        auto_en = 1'b1;
        cyc(2);
        chk("clamp_e2", digit, 8);
        cyc(1);
        chk("clamp_9", digit, 9);
        run_cnt(20);
        chk("clamp_hold", digit, 9);
        chk("clamp_nowrap", wraps, 0);
        load = 1'b0;
        cyc(7);
        chk("rel_e7", digit, 9);
        cyc(1);
        chk("rel_tick", digit, 0);
        chk("rel_tick_wrap", wrap, 1);
        auto_en = 1'b0;
        cyc(10);

        // Upper clamp boundary: load of exactly MAX_DIGIT and of 15
        load_val = 4'd15;
        load = 1'b1;
        cyc(4);
        chk("clamp_15", digit, 9);
        load_val = 4'd9;
        cyc(2);
        chk("load_max", digit, 9);

        // step_p and tick coincide: single step 3 -> 4
        load_val = 4'd3;
        cyc(2);
        chk("load3", digit, 3);
        load = 1'b0;
        cyc(4);
        auto_en = 1'b1;
        cyc(1);
        btn_step = 1'b1;
        cyc(6);
        chk("coinc_pre", digit, 3);
        cyc(1);
        chk("coinc_4", digit, 4);
        chk("coinc_wrap", wrap, 0);
        cyc(1);
        chk("coinc_hold", digit, 4);
        cyc(2);

        // Asynchronous reset mid-count with the button still held
        auto_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digit", digit, 0);
        chk("async_rst_wrap", wrap, 0);
        cyc(3);
        chk("rst_held", digit, 0);
        rst_n = 1'b1;
        cyc(6);
        chk("post_rst_e6", digit, 0);
        cyc(1);
        chk("post_rst_e7", digit, 1);
        run_cnt(15);
        chk("post_rst_single", digit, 1);
        chk("post_rst_nowrap", wraps, 0);
        btn_step = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
